recog_frame_sequencer: RTL

Frame-level controller for the colour-recognition path. It sits between the VGA/HDMI timing, the projection stage and the colour-count datapath. It sequences one recognition run: wait for a frame boundary, let projection settle, freeze the target window, clear and enable the colour accumulators for N frames, sample the winning colour code, then hold the result until the consumer acknowledges it.

---
 rtl/recog_frame_sequencer_pkg.sv | 43 ++++
 rtl/recog_frame_sequencer_frame_edge_det.sv | 24 ++
 rtl/recog_frame_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/recog_frame_sequencer_pkg.sv
// Shared definitions for the colour-recognition frame sequencer and its helpers.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package recog_frame_sequencer_pkg;

    // Sequencer state encodings
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_SYNC = 3'd1;
    localparam logic [2:0] ST_SETTLE    = 3'd2;
    localparam logic [2:0] ST_ACCUM     = 3'd3;
    localparam logic [2:0] ST_DECIDE    = 3'd4;
    localparam logic [2:0] ST_HOLD      = 3'd5;

    // Smallest usable window edge, in pixels
    localparam int MIN_WIN_DEF = 4;

    // Colour codes produced by the count datapath
    localparam logic [7:0] COLOR_NONE    = 8'h00;
    localparam logic [7:0] COLOR_RED     = 8'h01;
    localparam logic [7:0] COLOR_GREEN   = 8'h02;
    localparam logic [7:0] COLOR_BLUE    = 8'h03;
    localparam logic [7:0] COLOR_YELLOW  = 8'h04;
    localparam logic [7:0] COLOR_CYAN    = 8'h05;
    localparam logic [7:0] COLOR_MAGENTA = 8'h06;

    // Frozen target window, horizontal then vertical bounds
    typedef struct packed {
        logic [11:0] hl;
        logic [11:0] hr;
        logic [11:0] vl;
        logic [11:0] vr;
    } win_t;

    // One axis is unusable if reversed or narrower than min_win.
    // The span is formed in 13 bits so a full 4096-pixel span cannot wrap.
    function automatic logic axis_bad(input logic [11:0] lo, input logic [11:0] hi,
                                      input int min_win);
        logic [12:0] span;
        span = {1'b0, hi} - {1'b0, lo} + 13'd1;
        return (hi < lo) || (span < 13'(min_win));
    endfunction

endpackage

// File: rtl/recog_frame_sequencer_frame_edge_det.sv
// Frame-boundary detector: one-cycle tick on each vsync rising edge.
// Latency: combinational tick in the cycle vsync first reads high.
// Backpressure: none; the tick is a free-running strobe.
module frame_edge_det (
    input  logic pixelclk,
    input  logic reset,
    input  logic i_vsync,
    output logic o_tick
);

    logic vs_q;

    // Remember last cycle's vsync level for edge detection
    always_ff @(posedge pixelclk) begin
        if (reset) begin
            vs_q <= 1'b0;
        end else begin
            vs_q <= i_vsync;
        end
    end

    assign o_tick = i_vsync & ~vs_q;

endmodule

// File: rtl/recog_frame_sequencer.sv
// Sequences one colour-recognition run: sync, settle, freeze window, accumulate, sample, hold.
// Latency: result valid 2 cycles after the final accumulation tick (1 cycle after settle on error).
// Backpressure: result held with o_valid until i_ack; i_start outside IDLE is dropped.
module recog_frame_sequencer
    import recog_frame_sequencer_pkg::*;
#(
    parameter int SETTLE_FRAMES = 2,
    parameter int ACC_FRAMES    = 1,
    parameter int MIN_WIN       = MIN_WIN_DEF
) (
    input  logic        pixelclk,
    input  logic        reset,
    input  logic        i_start,
    input  logic        i_vsync,
    input  logic        i_de,
    input  logic [11:0] i_hcount_l,
    input  logic [11:0] i_hcount_r,
    input  logic [11:0] i_vcount_l,
    input  logic [11:0] i_vcount_r,
    input  logic [7:0]  i_color_code,
    input  logic        i_ack,
    output logic [2:0]  o_frame_cnt,
    output logic [11:0] o_win_hl,
    output logic [11:0] o_win_hr,
    output logic [11:0] o_win_vl,
    output logic [11:0] o_win_vr,
    output logic        o_acc_clear,
    output logic        o_acc_en,
    output logic        o_sample,
    output logic [7:0]  o_result,
    output logic        o_valid,
    output logic        o_err,
    output logic        o_busy
);

    logic [2:0] state;
    logic       tick;
    logic [2:0] cnt_inc;
    logic       settle_last;
    logic       acc_last;
    logic       win_bad;
    logic       acc_en_q;
    win_t       win_q;

    frame_edge_det u_edge (
        .pixelclk (pixelclk),
        .reset    (reset),
        .i_vsync  (i_vsync),
        .o_tick   (tick)
    );

    // Saturating next frame count and the run milestones it marks
    assign cnt_inc     = (o_frame_cnt == 3'd7) ? 3'd7 : o_frame_cnt + 3'd1;
    assign settle_last = tick && (cnt_inc == 3'(SETTLE_FRAMES));
    assign acc_last    = tick && (cnt_inc == 3'(SETTLE_FRAMES + ACC_FRAMES));
    assign win_bad     = axis_bad(i_hcount_l, i_hcount_r, MIN_WIN) |
                         axis_bad(i_vcount_l, i_vcount_r, MIN_WIN);

    // Accumulate only on active pixels, and never on the closing frame tick
    assign o_acc_en = acc_en_q & i_de & ~acc_last;

    assign o_win_hl = win_q.hl;
    assign o_win_hr = win_q.hr;
    assign o_win_vl = win_q.vl;
    assign o_win_vr = win_q.vr;

    // Run state machine with frame counter, window latch and result latch
    always_ff @(posedge pixelclk) begin
        if (reset) begin
            state       <= ST_IDLE;
            o_frame_cnt <= 3'd0;
            win_q       <= '0;
            o_acc_clear <= 1'b0;
            acc_en_q    <= 1'b0;
            o_sample    <= 1'b0;
            o_result    <= 8'd0;
            o_valid     <= 1'b0;
            o_err       <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_acc_clear <= 1'b0;
            o_sample    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state       <= ST_WAIT_SYNC;
                        o_frame_cnt <= 3'd0;
                        o_busy      <= 1'b1;
                    end
                end
                ST_WAIT_SYNC: begin
                    if (tick) begin
                        state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (tick) begin
                        o_frame_cnt <= cnt_inc;
                    end
                    if (settle_last) begin
                        win_q <= '{hl: i_hcount_l, hr: i_hcount_r,
                                   vl: i_vcount_l, vr: i_vcount_r};
                        if (win_bad) begin
                            o_err    <= 1'b1;
                            o_result <= COLOR_NONE;
                            o_valid  <= 1'b1;
                            state    <= ST_HOLD;
                        end else begin
                            o_err       <= 1'b0;
                            o_acc_clear <= 1'b1;
                            acc_en_q    <= 1'b1;
                            state       <= ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (tick) begin
                        o_frame_cnt <= cnt_inc;
                    end
                    if (acc_last) begin
                        acc_en_q <= 1'b0;
                        o_sample <= 1'b1;
                        state    <= ST_DECIDE;
                    end
                end
                ST_DECIDE: begin
                    o_result <= i_color_code;
                    o_valid  <= 1'b1;
                    state    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (i_ack) begin
                        o_valid <= 1'b0;
                        o_busy  <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    acc_en_q <= 1'b0;
                    o_valid  <= 1'b0;
                    o_busy   <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
